// File: rtl/frequency_measurement_scheduler.sv
// rtl/frequency_measurement_scheduler.sv - clear/measure/guard/transfer sequencer for the frequency analyzers
// Optional feature macro: SEQUENCE_COUNTER_EN (appends a commit-counter write to every result set).
module frequency_measurement_scheduler #(
    parameter int unsigned CLOCK_FREQUENCY       = 100000000,
    parameter int unsigned DEFAULT_WINDOW_CYCLES = CLOCK_FREQUENCY / 10,
    parameter int unsigned NUMBER_OF_RESULTS     = 9,
    parameter int unsigned GUARD_CYCLES          = 16,
    parameter int unsigned FIRST_REGISTER_NUMBER = 1
) (
    input  logic        clock,
    input  logic        reset,
    input  logic [31:0] cfg_window_cycles,
    input  logic        cfg_valid,
    input  logic        run,
    input  logic        single_shot,
    input  logic        abort,
    output logic        analyzer_enable,
    output logic        analyzer_clear,
    output logic [3:0]  result_index,
    input  logic [31:0] result_value,
    output logic [1:0]  register_operation,
    output logic [7:0]  register_number,
    output logic [31:0] register_write,
    input  logic        register_ack,
    output logic        busy,
    output logic        irq,
    input  logic        irq_ack,
    output logic        overrun
);

`ifdef SEQUENCE_COUNTER_EN
    localparam int unsigned NUMBER_OF_WRITES = NUMBER_OF_RESULTS + 1;
`else
    localparam int unsigned NUMBER_OF_WRITES = NUMBER_OF_RESULTS;
`endif

    localparam logic [3:0]  LAST_INDEX     = 4'(NUMBER_OF_WRITES);
    localparam logic [7:0]  FIRST_REGISTER = 8'(FIRST_REGISTER_NUMBER);
    localparam logic [31:0] DEFAULT_WINDOW = 32'(DEFAULT_WINDOW_CYCLES);
    localparam logic [31:0] GUARD_LOAD     = 32'(GUARD_CYCLES);

    typedef enum logic [2:0] {
        IDLE,
        CLEAR,
        MEASURE,
        GUARD,
        SELECT,
        WRITE,
        DONE,
        CLEAR_ABORT
    } state_t;

    state_t      state;
    state_t      next_state;
    logic [31:0] shadow_window;
    logic [31:0] cycle_count;
    logic [3:0]  index;

`ifdef SEQUENCE_COUNTER_EN
    logic [31:0] commit_count;
`endif

    always_comb begin
        next_state = state;
        case (state)
            IDLE:        if (run || single_shot) next_state = CLEAR;
            CLEAR:       next_state = MEASURE;
            MEASURE: begin
                if (abort)                  next_state = CLEAR_ABORT;
                else if (cycle_count == 1)  next_state = GUARD;
            end
            GUARD: begin
                if (abort)                  next_state = CLEAR_ABORT;
                else if (cycle_count == 1)  next_state = SELECT;
            end
            SELECT:      next_state = WRITE;
            WRITE: begin
                if (register_ack) next_state = (index == LAST_INDEX) ? DONE : SELECT;
            end
            DONE:        next_state = run ? CLEAR : IDLE;
            CLEAR_ABORT: next_state = IDLE;
            default:     next_state = IDLE;
        endcase
    end

    // Handshake outputs decode straight from state so a reset drops them on the very next edge.
    always_comb begin
        analyzer_clear     = (state == CLEAR) || (state == CLEAR_ABORT);
        analyzer_enable    = (state == MEASURE);
        busy               = (state != IDLE);
        result_index       = ((state == SELECT) || (state == WRITE)) ? index : 4'd0;
        register_operation = (state == WRITE) ? 2'd2 : 2'd0;
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state           <= IDLE;
            shadow_window   <= DEFAULT_WINDOW;
            cycle_count     <= 32'd0;
            index           <= 4'd0;
            register_number <= 8'd0;
            register_write  <= 32'd0;
            irq             <= 1'b0;
            overrun         <= 1'b0;
`ifdef SEQUENCE_COUNTER_EN
            commit_count    <= 32'd0;
`endif
        end else begin
            state <= next_state;

            if (cfg_valid) begin
                shadow_window <= (cfg_window_cycles == 32'd0) ? DEFAULT_WINDOW : cfg_window_cycles;
            end

            // Acknowledge first so a commit in the same cycle overrides it.
            if (irq_ack) irq <= 1'b0;

            case (state)
                CLEAR: begin
                    cycle_count <= shadow_window;
                    index       <= 4'd1;
                end
                MEASURE: begin
                    cycle_count <= (cycle_count == 32'd1) ? GUARD_LOAD : cycle_count - 32'd1;
                end
                GUARD: begin
                    cycle_count <= cycle_count - 32'd1;
                end
                SELECT: begin
                    register_number <= FIRST_REGISTER + {4'd0, index} - 8'd1;
`ifdef SEQUENCE_COUNTER_EN
                    register_write  <= (index == LAST_INDEX) ? commit_count : result_value;
`else
                    register_write  <= result_value;
`endif
                end
                WRITE: begin
                    if (register_ack) index <= index + 4'd1;
                end
                DONE: begin
                    irq <= 1'b1;
                    if (irq) overrun <= 1'b1;
`ifdef SEQUENCE_COUNTER_EN
                    commit_count <= commit_count + 32'd1;
`endif
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_frequency_measurement_scheduler.sv
// tb/tb_frequency_measurement_scheduler.sv - scoreboard bench for frequency_measurement_scheduler
module tb_frequency_measurement_scheduler;

    localparam int unsigned DEFAULT_WINDOW = 30;

    logic        clock = 1'b0;
    logic        reset = 1'b1;
    logic [31:0] cfg_window_cycles = 32'd0;
    logic        cfg_valid = 1'b0;
    logic        run = 1'b0;
    logic        single_shot = 1'b0;
    logic        abort = 1'b0;
    logic        analyzer_enable;
    logic        analyzer_clear;
    logic [3:0]  result_index;
    logic [31:0] result_value;
    logic [1:0]  register_operation;
    logic [7:0]  register_number;
    logic [31:0] register_write;
    logic        register_ack = 1'b0;
    logic        busy;
    logic        irq;
    logic        irq_ack = 1'b0;
    logic        overrun;

    frequency_measurement_scheduler #(
        .CLOCK_FREQUENCY       (DEFAULT_WINDOW * 10),
        .DEFAULT_WINDOW_CYCLES (DEFAULT_WINDOW),
        .NUMBER_OF_RESULTS     (9),
        .GUARD_CYCLES          (16),
        .FIRST_REGISTER_NUMBER (1)
    ) dut (
        .clock              (clock),
        .reset              (reset),
        .cfg_window_cycles  (cfg_window_cycles),
        .cfg_valid          (cfg_valid),
        .run                (run),
        .single_shot        (single_shot),
        .abort              (abort),
        .analyzer_enable    (analyzer_enable),
        .analyzer_clear     (analyzer_clear),
        .result_index       (result_index),
        .result_value       (result_value),
        .register_operation (register_operation),
        .register_number    (register_number),
        .register_write     (register_write),
        .register_ack       (register_ack),
        .busy               (busy),
        .irq                (irq),
        .irq_ack            (irq_ack),
        .overrun            (overrun)
    );

    always #5 clock = ~clock;

    // Analyzer result mux model: every result word is 0xA0 + its index.
    assign result_value = 32'hA0 + {28'd0, result_index};

    typedef struct packed {
        logic [7:0]  num;
        logic [31:0] data;
    } wr_t;

    wr_t sb[$];
    int  passes = 0;
    int  total = 0;
    int  seq = 0;
    int  ack_delay = 0;
    int  enable_cycles, clear_pulses, writes, gap_cycles, xfer_cycles;
    bit  seen_en, xfer_started;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got === exp) passes++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    endtask

    task automatic push_window();
        for (int i = 1; i <= 9; i++) sb.push_back({8'(i), 32'hA0 + 32'(i)});
`ifdef SEQUENCE_COUNTER_EN
        sb.push_back({8'd10, 32'(seq)});
`endif
        seq++;
    endtask

    task automatic reset_stats();
        enable_cycles = 0; clear_pulses = 0; writes = 0;
        gap_cycles = 0; xfer_cycles = 0; seen_en = 0; xfer_started = 0;
    endtask

    task automatic wait_idle(input int budget);
        int n = 0;
        while (busy && n < budget) begin
            @(negedge clock);
            n++;
        end
        if (n >= budget) check("timeout_idle", {31'd0, busy}, 32'd0);
    endtask

    task automatic wait_enable(input int budget);
        int n = 0;
        while (!analyzer_enable && n < budget) begin
            @(negedge clock);
            n++;
        end
        if (n >= budget) check("timeout_enable", {31'd0, analyzer_enable}, 32'd1);
    endtask

    task automatic pulse_single();
        @(negedge clock) single_shot = 1'b1;
        @(negedge clock) single_shot = 1'b0;
    endtask

    task automatic pulse_irq_ack();
        @(negedge clock) irq_ack = 1'b1;
        @(negedge clock) irq_ack = 1'b0;
    endtask

    task automatic load_cfg(input logic [31:0] w);
        @(negedge clock) begin cfg_window_cycles = w; cfg_valid = 1'b1; end
        @(negedge clock) cfg_valid = 1'b0;
    endtask

    // Register-bank model and write monitor; an accepted write pops the scoreboard.
    initial begin
        int  wcnt = 0;
        logic [1:0]  prev_op = 2'd0;
        bit          prev_acc = 0;
        logic [7:0]  prev_num = 8'd0;
        logic [31:0] prev_data = 32'd0;
        wr_t e;
        reset_stats();
        forever begin
            @(negedge clock);
            if (reset) begin
                wcnt = 0; register_ack = 1'b0; prev_op = 2'd0; prev_acc = 0;
            end else begin
                wcnt = (register_operation == 2'd2) ? wcnt + 1 : 0;
                register_ack = (ack_delay == 0) ? 1'b1 : (register_operation == 2'd2 && wcnt >= ack_delay);
                if (analyzer_enable) enable_cycles++;
                if (analyzer_clear) clear_pulses++;
                if (result_index != 4'd0) begin
                    xfer_cycles++;
                    xfer_started = 1;
                end else if (busy && !analyzer_enable && !analyzer_clear && seen_en && !xfer_started) begin
                    gap_cycles++;
                end
                if (analyzer_enable) seen_en = 1;
                if (register_operation == 2'd2 && prev_op == 2'd2 && !prev_acc) begin
                    check("hold_num", {24'd0, register_number}, {24'd0, prev_num});
                    check("hold_data", register_write, prev_data);
                end
                prev_acc = 0;
                if (register_operation == 2'd2 && register_ack) begin
                    prev_acc = 1;
                    writes++;
                    if (sb.size() == 0) begin
                        check("unexpected_write", {24'd0, register_number}, 32'hFFFF_FFFF);
                    end else begin
                        e = sb.pop_front();
                        check("wr_num", {24'd0, register_number}, {24'd0, e.num});
                        check("wr_data", register_write, e.data);
                    end
                end
                prev_op = register_operation;
                prev_num = register_number;
                prev_data = register_write;
            end
        end
    end

    initial begin
        int n;
        repeat (3) @(negedge clock);
        check("rst_busy", {31'd0, busy}, 32'd0);
        check("rst_enable", {31'd0, analyzer_enable}, 32'd0);
        check("rst_clear", {31'd0, analyzer_clear}, 32'd0);
        check("rst_op", {30'd0, register_operation}, 32'd0);
        check("rst_index", {28'd0, result_index}, 32'd0);
        check("rst_irq", {30'd0, irq, overrun}, 32'd0);
        reset = 1'b0;

        // Single window of 20, ack tied high.
        load_cfg(32'd20);
        reset_stats();
        push_window();
        pulse_single();
        wait_idle(400);
        check("t1_clear", 32'(clear_pulses), 32'd1);
        check("t1_enable", 32'(enable_cycles), 32'd20);
        check("t1_guard", 32'(gap_cycles), 32'd16);
`ifdef SEQUENCE_COUNTER_EN
        check("t1_xfer", 32'(xfer_cycles), 32'd20);
        check("t1_writes", 32'(writes), 32'd10);
`else
        check("t1_xfer", 32'(xfer_cycles), 32'd18);
        check("t1_writes", 32'(writes), 32'd9);
`endif
        check("t1_sb_empty", 32'(sb.size()), 32'd0);
        check("t1_irq", {30'd0, irq, overrun}, 32'd2);
        pulse_irq_ack();
        check("t1_irq_ack", {31'd0, irq}, 32'd0);

        // Slow register bank: ack on the 5th write cycle.
        ack_delay = 5;
        reset_stats();
        push_window();
        pulse_single();
        wait_idle(800);
`ifdef SEQUENCE_COUNTER_EN
        check("t2_xfer", 32'(xfer_cycles), 32'd60);
`else
        check("t2_xfer", 32'(xfer_cycles), 32'd54);
`endif
        check("t2_sb_empty", 32'(sb.size()), 32'd0);
        check("t2_irq", {30'd0, irq, overrun}, 32'd2);
        pulse_irq_ack();

        // Abort on the 10th MEASURE cycle.
        ack_delay = 1;
        reset_stats();
        pulse_single();
        wait_enable(10);
        repeat (9) @(negedge clock);
        abort = 1'b1;
        @(negedge clock) abort = 1'b0;
        check("t3_enable_drop", {31'd0, analyzer_enable}, 32'd0);
        check("t3_clear", {31'd0, analyzer_clear}, 32'd1);
        @(negedge clock);
        check("t3_idle", {31'd0, busy}, 32'd0);
        check("t3_enable_cycles", 32'(enable_cycles), 32'd10);
        check("t3_clear_pulses", 32'(clear_pulses), 32'd2);
        check("t3_writes", 32'(writes), 32'd0);
        check("t3_irq", {31'd0, irq}, 32'd0);

        // Back-to-back windows with irq left pending.
        load_cfg(32'd8);
        reset_stats();
        repeat (3) push_window();
        @(negedge clock) run = 1'b1;
        n = 0;
        while (!irq && n < 500) begin @(negedge clock); n++; end
        if (n >= 500) check("timeout_irq", {31'd0, irq}, 32'd1);
        check("t4_first_overrun", {31'd0, overrun}, 32'd0);
        n = 0;
        while (!overrun && n < 500) begin @(negedge clock); n++; end
        if (n >= 500) check("timeout_overrun", {31'd0, overrun}, 32'd1);
        run = 1'b0;
        wait_idle(500);
        check("t4_enable", 32'(enable_cycles), 32'd24);
        check("t4_clear", 32'(clear_pulses), 32'd3);
        check("t4_sb_empty", 32'(sb.size()), 32'd0);
        pulse_irq_ack();
        check("t4_irq_ack", {30'd0, irq, overrun}, 32'd1);

        // cfg 0 mid-window: current window unchanged, next uses default.
        load_cfg(32'd12);
        reset_stats();
        push_window();
        pulse_single();
        wait_enable(10);
        load_cfg(32'd0);
        wait_idle(400);
        check("t5_current", 32'(enable_cycles), 32'd12);
        reset_stats();
        push_window();
        pulse_single();
        wait_idle(400);
        check("t5_default", 32'(enable_cycles), 32'(DEFAULT_WINDOW));
        check("t5_sb_empty", 32'(sb.size()), 32'd0);

        // Reset in the middle of a transfer.
        ack_delay = 3;
        push_window();
        pulse_single();
        n = 0;
        while (register_operation != 2'd2 && n < 200) begin @(negedge clock); n++; end
        if (n >= 200) check("timeout_write", {30'd0, register_operation}, 32'd2);
        reset = 1'b1;
        @(negedge clock);
        check("t6_op", {30'd0, register_operation}, 32'd0);
        check("t6_busy", {31'd0, busy}, 32'd0);
        check("t6_flags", {30'd0, irq, overrun}, 32'd0);
        reset = 1'b0;
        sb.delete();
        seq = 0;

        // After reset the shadow window is the default again.
        ack_delay = 1;
        reset_stats();
        push_window();
        pulse_single();
        wait_idle(400);
        check("t6_default", 32'(enable_cycles), 32'(DEFAULT_WINDOW));
        check("t6_sb_empty", 32'(sb.size()), 32'd0);

        $display("%0d/%0d checks passed", passes, total);
        $finish;
    end

endmodule
